// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, LSB-first payload, optional parity, stop bits.
// Define UART_TX_PARITY_EN to build in the parity bit (sense chosen by PARITY_ODD).
module uart_tx_cfg #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic                 bit_end_c;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign bit_end_c = (cnt_q == CNT_W'(CLK_DIV - 1));

  // State and output registers; reset parks the line idle and ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state: tx_d is the level the line takes for the upcoming bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != IDLE) begin
      cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && ready_q) begin
          state_d = START;
          tx_d    = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          data_d  = tx_data;
          busy_d  = 1'b1;
          ready_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: begin
        if (bit_end_c) begin
          state_d = DATA;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            data_d = data_q >> 1;
            tx_d   = data_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_c) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end_c) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            state_d = IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_ready = ready_q;

  // Illegal parameter combinations are flagged in simulation only.
  param_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
    (CLK_DIV >= 2) && (CLK_DIV <= 65535) && (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
    (STOP_BITS >= 1) && (STOP_BITS <= 2) && (PARITY_ODD <= 1));

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: three configurations, expected frames queued at acceptance.
module tb_uart_tx_cfg;

  typedef struct {
    string       name;
    int unsigned data;
    int unsigned nbits;
    int unsigned sbits;
    int unsigned div;
    int unsigned has_par;
    int unsigned par_bit;
    int unsigned len;
  } exp_t;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned PAR_ON = 1;
  localparam int unsigned LEN_8N = 44;
  localparam int unsigned LEN_7S = 33;
`else
  localparam int unsigned PAR_ON = 0;
  localparam int unsigned LEN_8N = 40;
  localparam int unsigned LEN_7S = 30;
`endif

  logic       clk;
  logic       rst_n, rst_a_n;
  logic [7:0] data_a, data_c;
  logic [6:0] data_b;
  logic       valid_a, valid_b, valid_c;
  logic       ready_a, ready_b, ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t exp_a[$], exp_b[$], exp_c[$];
  bit   buf_a[$], buf_b[$], buf_c[$];
  logic pb_a = 1'b0, pb_b = 1'b0, pb_c = 1'b0;

  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst_n(rst_a_n), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a));

  uart_tx_cfg #(.CLK_DIV(3), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b));

  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_c (
    .clk(clk), .rst_n(rst_n), .tx_data(data_c), .tx_valid(valid_c),
    .tx_ready(ready_c), .tx(tx_c), .tx_busy(busy_c), .tx_done(done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(string name, int unsigned data, int unsigned nbits,
                              int unsigned sbits, int unsigned div, int unsigned par_bit,
                              int unsigned len);
    exp_t e;
    e.name = name; e.data = data; e.nbits = nbits; e.sbits = sbits; e.div = div;
    e.has_par = PAR_ON; e.par_bit = par_bit; e.len = len;
    return e;
  endfunction

  // Compare a captured busy-window of line samples against the ideal frame waveform.
  function automatic void check_frame(exp_t e, bit b[$], logic pb);
    bit          w[$];
    int          first_bad = -1;
    int unsigned d = 0;
    int          nmax;
    for (int k = 0; k < int'(e.div); k++) w.push_back(1'b0);
    for (int i = 0; i < int'(e.nbits); i++)
      for (int k = 0; k < int'(e.div); k++) w.push_back(((e.data >> i) & 1) != 0);
    if (e.has_par != 0)
      for (int k = 0; k < int'(e.div); k++) w.push_back(e.par_bit != 0);
    for (int k = 0; k < int'(e.sbits * e.div); k++) w.push_back(1'b1);
    nmax = (b.size() > w.size()) ? b.size() : w.size();
    for (int i = 0; i < nmax; i++) begin
      if (first_bad < 0 && (i >= b.size() || i >= w.size() || b[i] != w[i])) first_bad = i;
    end
    check({e.name, " frame_len"}, b.size(), e.len);
    check({e.name, " wave_first_bad_idx"}, first_bad, 32'hFFFF_FFFF);
    for (int i = 0; i < int'(e.nbits); i++) begin
      int idx = (1 + i) * int'(e.div) + int'(e.div) / 2;
      if (idx < b.size() && b[idx]) d |= (1 << i);
    end
    check({e.name, " decoded"}, d, e.data);
    if (e.has_par != 0) begin
      int pidx = (1 + int'(e.nbits)) * int'(e.div) + int'(e.div) / 2;
      check({e.name, " parity"}, (pidx < b.size()) ? 32'(b[pidx]) : 32'hDEAD, e.par_bit);
    end
    check({e.name, " done_follows_busy"}, pb, 1);
  endfunction

  // Monitors: collect line samples while busy, score on each tx_done.
  always @(negedge clk) begin
    if (!rst_a_n) buf_a.delete();
    else begin
      if (busy_a) buf_a.push_back(tx_a);
      if (done_a) begin
        check("a done_has_expectation", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) check_frame(exp_a.pop_front(), buf_a, pb_a);
        buf_a.delete();
      end
    end
    pb_a = busy_a;
  end

  always @(negedge clk) begin
    if (!rst_n) buf_b.delete();
    else begin
      if (busy_b) buf_b.push_back(tx_b);
      if (done_b) begin
        check("b done_has_expectation", exp_b.size() > 0, 1);
        if (exp_b.size() > 0) check_frame(exp_b.pop_front(), buf_b, pb_b);
        buf_b.delete();
      end
    end
    pb_b = busy_b;
  end

  always @(negedge clk) begin
    if (!rst_n) buf_c.delete();
    else begin
      if (busy_c) buf_c.push_back(tx_c);
      if (done_c) begin
        check("c done_has_expectation", exp_c.size() > 0, 1);
        if (exp_c.size() > 0) check_frame(exp_c.pop_front(), buf_c, pb_c);
        buf_c.delete();
      end
    end
    pb_c = busy_c;
  end

  function automatic logic rdy(int which);
    case (which)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  // Wait (bounded) for ready, present one payload for one accepting edge, queue expectation.
  task automatic send(int which, logic [8:0] d, exp_t e, bit push);
    int n = 0;
    while (!rdy(which) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check({e.name, " ready_before_send"}, rdy(which), 1);
    case (which)
      0:       begin data_a = d[7:0]; valid_a = 1'b1; end
      1:       begin data_b = d[6:0]; valid_b = 1'b1; end
      default: begin data_c = d[7:0]; valid_c = 1'b1; end
    endcase
    @(posedge clk);
    if (push) begin
      case (which)
        0:       exp_a.push_back(e);
        1:       exp_b.push_back(e);
        default: exp_c.push_back(e);
      endcase
    end
    #1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst_a_n = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    #12;
    check("rst tx_a", tx_a, 1);
    check("rst ready_a", ready_a, 1);
    check("rst busy_a", busy_a, 0);
    check("rst done_a", done_a, 0);
    check("rst tx_b", tx_b, 1);
    check("rst ready_c", ready_c, 1);

    // 0x55 offered before reset release: accepted on the first edge after it.
    valid_a = 1'b1; data_a = 8'h55;
    @(posedge clk); #1;
    rst_n = 1'b1; rst_a_n = 1'b1;
    @(posedge clk);
    exp_a.push_back(mk("a 0x55", 32'h55, 8, 1, 4, 0, LEN_8N));
    #1;
    check("latency tx_low", tx_a, 0);
    check("latency busy", busy_a, 1);
    check("latency ready_low", ready_a, 0);
    valid_a = 1'b0; data_a = 8'hFF;
    repeat (LEN_8N - 1) @(posedge clk);
    #1 check("done_not_early", done_a, 0);
    @(posedge clk); #1;
    check("done_at_len_plus_1", done_a, 1);
    check("ready_after_frame", ready_a, 1);
    check("busy_after_frame", busy_a, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done_a, 0);

    // Parity sense: 0x07 has three ones (even->1, odd->0).
    send(0, 9'h07, mk("a 0x07 even", 32'h07, 8, 1, 4, 1, LEN_8N), 1'b1);
    send(2, 9'h07, mk("c 0x07 odd", 32'h07, 8, 1, 4, 0, LEN_8N), 1'b1);

    // 7 data bits, 2 stop bits; data input changes mid-frame must not matter.
    send(1, 9'h4B, mk("b 0x4B", 32'h4B, 7, 2, 3, 0, LEN_7S), 1'b1);
    #20 data_b = 7'h34;

    // Back-to-back with tx_valid held: exactly one idle clock between frames.
    begin
      int n = 0;
      while (!ready_a && n < 300) begin @(posedge clk); #1; n++; end
      check("b2b ready", ready_a, 1);
      valid_a = 1'b1; data_a = 8'hA5;
      @(posedge clk);
      exp_a.push_back(mk("a 0xA5", 32'hA5, 8, 1, 4, 0, LEN_8N));
      #1 data_a = 8'h3C;
      repeat (LEN_8N) @(posedge clk);
      #1;
      check("b2b idle_clock_tx", tx_a, 1);
      check("b2b idle_clock_ready", ready_a, 1);
      @(posedge clk);
      exp_a.push_back(mk("a 0x3C", 32'h3C, 8, 1, 4, 0, LEN_8N));
      #1;
      check("b2b second_start", tx_a, 0);
      check("b2b second_busy", busy_a, 1);
      valid_a = 1'b0;
    end

    // Abort 0xF0 during data bit 3 (cycles 17..20 after acceptance), then send 0x81.
    send(0, 9'hF0, mk("a 0xF0 aborted", 32'hF0, 8, 1, 4, 0, LEN_8N), 1'b0);
    repeat (17) @(posedge clk);
    #3 check("abort pre tx bit3", tx_a, 0);
    rst_a_n = 1'b0;
    #1;
    check("abort tx", tx_a, 1);
    check("abort ready", ready_a, 1);
    check("abort busy", busy_a, 0);
    check("abort done", done_a, 0);
    @(posedge clk); #1 rst_a_n = 1'b1;
    send(0, 9'h81, mk("a 0x81", 32'h81, 8, 1, 4, 0, LEN_8N), 1'b1);

    // Drain scoreboard, then linger to catch stray tx_done pulses.
    for (int i = 0; i < 2000 && (exp_a.size() + exp_b.size() + exp_c.size()) > 0; i++)
      @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    check("a pending", exp_a.size(), 0);
    check("b pending", exp_b.size(), 0);
    check("c pending", exp_c.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
